// File: rtl/processing_unit_v3.sv
// Union-find decoder PE for one Z-type ancilla: measurement FIFO, grow pulse, merge.
// Optional PU_MERGE_CYCLE_COUNT_EN adds a saturating merge_cycles activity counter.
module processing_unit_v3 #(
   parameter int PER_DIM_BIT_WIDTH = 2,
   parameter int NEIGHBOR_COUNT    = 6,
   parameter logic [3*PER_DIM_BIT_WIDTH-1:0] ADDRESS = '0,
   parameter int STAGE_WIDTH       = 3,
   parameter int MEAS_DEPTH        = 4,
   parameter int QUIET_CYCLES      = 2,
   localparam int ADDRESS_WIDTH    = 3*PER_DIM_BIT_WIDTH,
   localparam int COUNT_WIDTH      = $clog2(MEAS_DEPTH)+1
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic [STAGE_WIDTH-1:0]                  global_stage,
   input  logic                                    meas_valid,
   input  logic                                    meas_data,
   output logic                                    meas_ready,
   output logic [COUNT_WIDTH-1:0]                  meas_count,
   output logic                                    load_underflow,
   input  logic [NEIGHBOR_COUNT-1:0]               neighbor_fully_grown,
   input  logic [NEIGHBOR_COUNT*ADDRESS_WIDTH-1:0] neighbor_root,
   input  logic [NEIGHBOR_COUNT-1:0]               neighbor_parent_vector,
   input  logic [NEIGHBOR_COUNT-1:0]               neighbor_is_boundary,
   input  logic [NEIGHBOR_COUNT-1:0]               parent_odd,
   input  logic [NEIGHBOR_COUNT-1:0]               child_cluster_parity,
   input  logic [NEIGHBOR_COUNT-1:0]               child_touching_boundary,
   output logic                                    neighbor_increase,
   output logic [NEIGHBOR_COUNT-1:0]               parent_vector,
   output logic                                    cluster_parity,
   output logic                                    cluster_touching_boundary,
   output logic                                    odd,
   output logic [ADDRESS_WIDTH-1:0]                root,
`ifdef PU_MERGE_CYCLE_COUNT_EN
   output logic [15:0]                             merge_cycles,
`endif
   output logic                                    busy
);

   localparam int PTR_WIDTH   = $clog2(MEAS_DEPTH);
   localparam int QUIET_WIDTH = $clog2(QUIET_CYCLES+2);

   localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE    = STAGE_WIDTH'(0);
   localparam logic [STAGE_WIDTH-1:0] STAGE_LOADING = STAGE_WIDTH'(1);
   localparam logic [STAGE_WIDTH-1:0] STAGE_GROW    = STAGE_WIDTH'(2);
   localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE   = STAGE_WIDTH'(3);

   // Stage tracking
   logic [STAGE_WIDTH-1:0] r_stage;
   logic [STAGE_WIDTH-1:0] r_last_stage;
   logic                   w_load_entry;
   logic                   w_merge;

   // Measurement FIFO
   logic                   r_mem [MEAS_DEPTH];
   logic [PTR_WIDTH-1:0]   r_wr_ptr;
   logic [PTR_WIDTH-1:0]   r_rd_ptr;
   logic [COUNT_WIDTH-1:0] r_count;
   logic                   r_underflow;
   logic                   w_full;
   logic                   w_empty;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_load_bit;

   // Cluster state
   logic                      r_m;
   logic [ADDRESS_WIDTH-1:0]  r_root;
   logic [NEIGHBOR_COUNT-1:0] r_parent_vector;
   logic                      r_cluster_parity;
   logic                      r_touching;
   logic                      r_odd;
   logic                      r_busy;
   logic [QUIET_WIDTH-1:0]    r_quiet;

   // Merge evaluation
   logic                      w_any_grown;
   logic [ADDRESS_WIDTH-1:0]  w_min_root;
   logic [NEIGHBOR_COUNT-1:0] w_sel_onehot;
   logic                      w_root_update;
   logic                      w_next_parity;
   logic                      w_next_boundary;
   logic                      w_next_odd;
   logic                      w_change;
   logic [QUIET_WIDTH-1:0]    w_quiet_inc;
   logic                      w_quiet_done;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stage      <= STAGE_IDLE;
         r_last_stage <= STAGE_IDLE;
      end else begin
         // NOTE: non-blocking so r_last_stage takes the pre-edge r_stage.
         r_stage      <= global_stage;
         r_last_stage <= r_stage;
      end
   end

   assign w_load_entry = (r_stage == STAGE_LOADING) && (r_last_stage != STAGE_LOADING);
   assign w_merge      = (r_stage == STAGE_MERGE);

   assign w_full     = (r_count == COUNT_WIDTH'(MEAS_DEPTH));
   assign w_empty    = (r_count == '0);
   assign meas_ready = !reset && !w_full;
   assign w_push     = meas_valid && meas_ready;
   assign w_pop      = w_load_entry && !w_empty;
   assign w_load_bit = w_empty ? 1'b0 : r_mem[r_rd_ptr];

   // NOTE: storage is not reset; occupancy and pointers alone define validity.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= meas_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_underflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_WIDTH'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_WIDTH'(1);
         if (w_push && !w_pop)      r_count <= r_count + COUNT_WIDTH'(1);
         else if (w_pop && !w_push) r_count <= r_count - COUNT_WIDTH'(1);
         if (w_load_entry && w_empty) r_underflow <= 1'b1;
      end
   end

   // Lowest root among fully grown channels; strict < keeps the lowest index on ties.
   always_comb begin
      w_any_grown  = 1'b0;
      w_min_root   = '0;
      w_sel_onehot = '0;
      for (int i = 0; i < NEIGHBOR_COUNT; i++) begin
         if (neighbor_fully_grown[i] &&
             (!w_any_grown || (neighbor_root[i*ADDRESS_WIDTH +: ADDRESS_WIDTH] < w_min_root))) begin
            w_any_grown     = 1'b1;
            w_min_root      = neighbor_root[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            w_sel_onehot    = '0;
            w_sel_onehot[i] = 1'b1;
         end
      end
   end

   assign w_root_update   = w_any_grown && (w_min_root < r_root);
   assign w_next_parity   = ^(neighbor_parent_vector & child_cluster_parity) ^ r_m;
   assign w_next_boundary = |(neighbor_parent_vector & child_touching_boundary) |
                            |neighbor_is_boundary;
   assign w_next_odd      = (r_parent_vector != '0) ? |(r_parent_vector & parent_odd)
                                                    : (w_next_parity & ~w_next_boundary);
   assign w_change        = w_root_update ||
                            (w_next_parity != r_cluster_parity) ||
                            (w_next_boundary != r_touching) ||
                            (w_next_odd != r_odd);
   assign w_quiet_inc     = r_quiet + QUIET_WIDTH'(1);
   assign w_quiet_done    = (w_quiet_inc >= QUIET_WIDTH'(QUIET_CYCLES));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_m              <= 1'b0;
         r_root           <= ADDRESS;
         r_parent_vector  <= '0;
         r_cluster_parity <= 1'b0;
         r_touching       <= 1'b0;
         r_odd            <= 1'b0;
         r_busy           <= 1'b0;
         r_quiet          <= '0;
      end else if (w_load_entry) begin
         r_m              <= w_load_bit;
         r_cluster_parity <= w_load_bit;
         r_odd            <= w_load_bit;
         r_touching       <= 1'b0;
         r_root           <= ADDRESS;
         r_parent_vector  <= '0;
         r_busy           <= 1'b0;
         r_quiet          <= '0;
      end else if (w_merge) begin
         if (w_root_update) begin
            r_root          <= w_min_root;
            r_parent_vector <= w_sel_onehot;
         end
         r_cluster_parity <= w_next_parity;
         r_touching       <= w_next_boundary;
         r_odd            <= w_next_odd;
         if (w_change) begin
            r_busy  <= 1'b1;
            r_quiet <= '0;
         end else begin
            r_quiet <= (w_quiet_inc > QUIET_WIDTH'(QUIET_CYCLES)) ? QUIET_WIDTH'(QUIET_CYCLES)
                                                                  : w_quiet_inc;
            if (w_quiet_done) r_busy <= 1'b0;
         end
      end
   end

`ifdef PU_MERGE_CYCLE_COUNT_EN
   logic [15:0] r_merge_cycles;

   always_ff @(posedge clk) begin
      if (reset || w_load_entry) begin
         r_merge_cycles <= '0;
      end else if (w_merge && (r_busy || w_change) && (r_merge_cycles != 16'hFFFF)) begin
         r_merge_cycles <= r_merge_cycles + 16'd1;
      end
   end

   assign merge_cycles = r_merge_cycles;
`endif

   assign neighbor_increase         = r_odd && (r_stage == STAGE_GROW) && (r_last_stage != STAGE_GROW);
   assign meas_count                = r_count;
   assign load_underflow            = r_underflow;
   assign parent_vector             = r_parent_vector;
   assign cluster_parity            = r_cluster_parity;
   assign cluster_touching_boundary = r_touching;
   assign odd                       = r_odd;
   assign root                      = r_root;
   assign busy                      = r_busy;

endmodule

// File: tb/tb_processing_unit_v3.sv
// Bench for processing_unit_v3: directed scenarios plus random stimulus against a
// transaction-level model (FIFO as a queue, merge from the cluster rules).
module tb_processing_unit_v3;

   localparam int NC    = 6;
   localparam int AW    = 6;
   localparam int DEPTH = 4;
   localparam int QC    = 2;
   localparam int ADDR  = 5;

   logic            clk = 1'b0;
   logic            reset;
   logic [2:0]      global_stage;
   logic            meas_valid;
   logic            meas_data;
   logic            meas_ready;
   logic [2:0]      meas_count;
   logic            load_underflow;
   logic [NC-1:0]   neighbor_fully_grown;
   logic [NC*AW-1:0] neighbor_root;
   logic [NC-1:0]   neighbor_parent_vector;
   logic [NC-1:0]   neighbor_is_boundary;
   logic [NC-1:0]   parent_odd;
   logic [NC-1:0]   child_cluster_parity;
   logic [NC-1:0]   child_touching_boundary;
   logic            neighbor_increase;
   logic [NC-1:0]   parent_vector;
   logic            cluster_parity;
   logic            cluster_touching_boundary;
   logic            odd;
   logic [AW-1:0]   root;
   logic            busy;
`ifdef PU_MERGE_CYCLE_COUNT_EN
   logic [15:0]     merge_cycles;
`endif

   processing_unit_v3 #(.ADDRESS(6'd5)) dut (
      .clk                       (clk),
      .reset                     (reset),
      .global_stage              (global_stage),
      .meas_valid                (meas_valid),
      .meas_data                 (meas_data),
      .meas_ready                (meas_ready),
      .meas_count                (meas_count),
      .load_underflow            (load_underflow),
      .neighbor_fully_grown      (neighbor_fully_grown),
      .neighbor_root             (neighbor_root),
      .neighbor_parent_vector    (neighbor_parent_vector),
      .neighbor_is_boundary      (neighbor_is_boundary),
      .parent_odd                (parent_odd),
      .child_cluster_parity      (child_cluster_parity),
      .child_touching_boundary   (child_touching_boundary),
      .neighbor_increase         (neighbor_increase),
      .parent_vector             (parent_vector),
      .cluster_parity            (cluster_parity),
      .cluster_touching_boundary (cluster_touching_boundary),
      .odd                       (odd),
      .root                      (root),
`ifdef PU_MERGE_CYCLE_COUNT_EN
      .merge_cycles              (merge_cycles),
`endif
      .busy                      (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   bit        mq[$];
   int        mdl_stage, mdl_last;
   bit        mdl_underflow, mdl_m, mdl_par, mdl_tb, mdl_odd, mdl_busy;
   int        mdl_root, mdl_quiet;
   bit [NC-1:0] mdl_pv;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int nroot(input int i);
      return int'(neighbor_root[i*AW +: AW]);
   endfunction

   task automatic model_clock();
      bit le, b, np, nb, nodd, upd, chg, found;
      int minr, sel;
      if (reset) begin
         mq.delete();
         mdl_stage = 0; mdl_last = 0; mdl_underflow = 0; mdl_m = 0;
         mdl_root = ADDR; mdl_pv = '0; mdl_par = 0; mdl_tb = 0;
         mdl_odd = 0; mdl_busy = 0; mdl_quiet = 0;
         return;
      end
      le = (mdl_stage == 1) && (mdl_last != 1);
      if (le) begin
         if (mq.size() > 0) b = mq[0];
         else begin
            b = 0;
            mdl_underflow = 1;
         end
         mdl_m = b; mdl_par = b; mdl_odd = b; mdl_tb = 0;
         mdl_root = ADDR; mdl_pv = '0; mdl_busy = 0; mdl_quiet = 0;
      end else if (mdl_stage == 3) begin
         found = 0; minr = 0;
         for (int i = 0; i < NC; i++)
            if (neighbor_fully_grown[i] && (!found || nroot(i) < minr)) begin
               minr = nroot(i);
               found = 1;
            end
         sel = -1;
         for (int i = NC-1; i >= 0; i--)
            if (neighbor_fully_grown[i] && nroot(i) == minr) sel = i;
         upd  = found && (minr < mdl_root);
         np   = (($countones(neighbor_parent_vector & child_cluster_parity) % 2) == 1) ^ mdl_m;
         nb   = ((neighbor_parent_vector & child_touching_boundary) != 0) || (neighbor_is_boundary != 0);
         nodd = (mdl_pv != 0) ? ((mdl_pv & parent_odd) != 0) : (np && !nb);
         chg  = upd || (np != mdl_par) || (nb != mdl_tb) || (nodd != mdl_odd);
         if (upd) begin
            mdl_root = minr;
            mdl_pv   = NC'(1) << sel;
         end
         mdl_par = np; mdl_tb = nb; mdl_odd = nodd;
         if (chg) begin
            mdl_busy  = 1;
            mdl_quiet = 0;
         end else begin
            if (mdl_quiet + 1 >= QC) mdl_busy = 0;
            mdl_quiet = (mdl_quiet + 1 > QC) ? QC : mdl_quiet + 1;
         end
      end
      // FIFO: a full FIFO rejects the push even when this cycle also pops.
      begin
         bit push;
         push = meas_valid && (mq.size() < DEPTH);
         if (le && mq.size() > 0) void'(mq.pop_front());
         if (push) mq.push_back(meas_data);
      end
      mdl_last  = mdl_stage;
      mdl_stage = int'(global_stage);
   endtask

   task automatic compare_all();
      check("meas_ready", meas_ready, (!reset && mq.size() < DEPTH));
      check("meas_count", meas_count, mq.size());
      check("load_underflow", load_underflow, mdl_underflow);
      check("root", root, mdl_root);
      check("parent_vector", parent_vector, mdl_pv);
      check("cluster_parity", cluster_parity, mdl_par);
      check("touching_boundary", cluster_touching_boundary, mdl_tb);
      check("odd", odd, mdl_odd);
      check("busy", busy, mdl_busy);
      check("neighbor_increase", neighbor_increase, (mdl_odd && mdl_stage == 2 && mdl_last != 2));
   endtask

   task automatic step();
      @(posedge clk);
      model_clock();
      @(negedge clk);
      compare_all();
   endtask

   task automatic do_load();
      global_stage = 3'd1;
      step();
      step();
      global_stage = 3'd0;
      step();
      step();
   endtask

   task automatic clear_neighbors();
      neighbor_fully_grown    = '0;
      neighbor_root           = '1;
      neighbor_parent_vector  = '0;
      neighbor_is_boundary    = '0;
      parent_odd              = '0;
      child_cluster_parity    = '0;
      child_touching_boundary = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit exp1 [3];
      bit d [5];
      exp1[0] = 1; exp1[1] = 0; exp1[2] = 1;
      reset = 1; global_stage = 0; meas_valid = 0; meas_data = 0;
      clear_neighbors();
      repeat (3) step();
      check("rst_root", root, ADDR);
      check("rst_count", meas_count, 0);
      reset = 0;

      // Push 1,0,1 then three loads.
      meas_valid = 1;
      meas_data = 1; step();
      meas_data = 0; step();
      meas_data = 1; step();
      meas_valid = 0;
      check("s1_count3", meas_count, 3);
      for (int k = 0; k < 3; k++) begin
         do_load();
         check("s1_odd", odd, exp1[k]);
         check("s1_parity", cluster_parity, exp1[k]);
      end
      check("s1_count0", meas_count, 0);
      check("s1_underflow", load_underflow, 0);

      // Fill, offer a fifth bit, then a load with valid still high.
      for (int k = 0; k < 5; k++) d[k] = 1'($urandom);
      meas_valid = 1;
      for (int k = 0; k < 4; k++) begin
         meas_data = d[k];
         step();
      end
      meas_data = d[4];
      check("s2_ready_full", meas_ready, 0);
      check("s2_count_full", meas_count, 4);
      step();
      check("s2_count_reject", meas_count, 4);
      global_stage = 3'd1;
      step();
      check("s2_count_entry", meas_count, 4);
      step();
      check("s2_count_pop", meas_count, 3);
      check("s2_ready_pop", meas_ready, 1);
      check("s2_odd", odd, d[0]);
      step();
      check("s2_count_refill", meas_count, 4);
      meas_valid = 0;
      global_stage = 3'd0;
      step();
      step();

      // Drain, then load from an empty FIFO.
      for (int k = 1; k < 5; k++) begin
         do_load();
         check("s3_odd_drain", odd, d[k]);
      end
      check("s3_underflow_pre", load_underflow, 0);
      do_load();
      check("s3_odd_empty", odd, 0);
      check("s3_parity_empty", cluster_parity, 0);
      check("s3_underflow", load_underflow, 1);
      do_load();
      check("s3_underflow_sticky", load_underflow, 1);

      // Merge: channels 1 and 3 grown with root 2.
      neighbor_fully_grown = 6'b001010;
      neighbor_root[1*AW +: AW] = 6'd2;
      neighbor_root[3*AW +: AW] = 6'd2;
      global_stage = 3'd3;
      step();
      step();
      check("s4_root", root, 2);
      check("s4_pv", parent_vector, 6'b000010);
      check("s4_busy", busy, 1);
      step();
      check("s4_busy_quiet1", busy, 1);
      step();
      check("s4_busy_quiet2", busy, 0);
      global_stage = 3'd0;
      clear_neighbors();
      step();
      step();

      // Root PE with m=1 and channel 0 on the boundary.
      meas_valid = 1; meas_data = 1;
      step();
      meas_valid = 0;
      do_load();
      check("s5_odd_loaded", odd, 1);
      neighbor_is_boundary = 6'b000001;
      global_stage = 3'd3;
      step();
      step();
      check("s5_boundary", cluster_touching_boundary, 1);
      check("s5_odd", odd, 0);
      global_stage = 3'd2;
      step();
      check("s5_no_increase", neighbor_increase, 0);
      global_stage = 3'd0;
      clear_neighbors();
      step();
      step();

      // Reset during MERGE with two bits queued.
      meas_valid = 1; meas_data = 1;
      step();
      step();
      meas_valid = 0;
      neighbor_fully_grown = 6'b000001;
      neighbor_root[0 +: AW] = 6'd1;
      global_stage = 3'd3;
      step();
      step();
      check("s6_busy_pre", busy, 1);
      check("s6_count_pre", meas_count, 2);
      reset = 1;
      global_stage = 3'd0;
      step();
      check("s6_root", root, ADDR);
      check("s6_busy", busy, 0);
      check("s6_count", meas_count, 0);
      check("s6_ready_in_reset", meas_ready, 0);
      reset = 0;
      #1;
      check("s6_ready_after", meas_ready, 1);
      clear_neighbors();

      // Random phase: stages held for a few cycles with random neighbour state.
      for (int it = 0; it < 400; it++) begin
         int hold;
         global_stage            = 3'($urandom_range(0, 3));
         neighbor_fully_grown    = NC'($urandom);
         for (int i = 0; i < NC; i++) neighbor_root[i*AW +: AW] = AW'($urandom_range(0, 8));
         neighbor_parent_vector  = NC'($urandom);
         neighbor_is_boundary    = ($urandom_range(0, 3) == 0) ? NC'($urandom) : '0;
         parent_odd              = NC'($urandom);
         child_cluster_parity    = NC'($urandom);
         child_touching_boundary = ($urandom_range(0, 2) == 0) ? NC'($urandom) : '0;
         hold = $urandom_range(1, 6);
         for (int c = 0; c < hold; c++) begin
            meas_valid = 1'($urandom);
            meas_data  = 1'($urandom);
            reset      = ($urandom_range(0, 199) == 0);
            step();
         end
      end
      reset = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/processing_unit_v3.md
Name: processing_unit_v3

Overview:
- Union-find decoder processing element for one Z-type ancilla at a 3-D lattice vertex.
- Successor PE generalised in neighbour count and address width. Adds a streamed multi-round measurement FIFO with valid/ready handshake, deterministic one-hot parent selection, and a quiet-cycle busy filter.
- Sits in the PE array. Receives global_stage from the decoder controller and exchanges root/parity/boundary/odd signals with its neighbours.

Parameters:
- PER_DIM_BIT_WIDTH, 2, bits per lattice coordinate; ADDRESS_WIDTH = 3*PER_DIM_BIT_WIDTH.
- NEIGHBOR_COUNT, 6, neighbour channels, 1..16.
- ADDRESS, 0, this PE's {M,X,Z} address.
- STAGE_WIDTH, 3, stage code width.
- MEAS_DEPTH, 4, measurement FIFO depth, power of 2, >=2.
- QUIET_CYCLES, 2, consecutive unchanged merge cycles before busy deasserts, >=1.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- global_stage  in  STAGE_WIDTH  controller stage: IDLE=0, MEASUREMENT_LOADING=1, GROW=2, MERGE=3
- meas_valid  in  1  measurement bit offered
- meas_data  in  1  measurement bit
- meas_ready  out  1  FIFO can accept
- meas_count  out  $clog2(MEAS_DEPTH)+1  FIFO occupancy
- load_underflow  out  1  sticky: a load occurred with the FIFO empty
- neighbor_fully_grown  in  NEIGHBOR_COUNT  edge fully grown, per channel
- neighbor_root  in  NEIGHBOR_COUNT*ADDRESS_WIDTH  neighbour roots; channel i at [i*AW +: AW]
- neighbor_parent_vector  in  NEIGHBOR_COUNT  neighbour i has this PE as parent
- neighbor_is_boundary  in  NEIGHBOR_COUNT  edge i is grown to the boundary
- parent_odd  in  NEIGHBOR_COUNT  odd of neighbour i
- child_cluster_parity  in  NEIGHBOR_COUNT  subtree parity of neighbour i
- child_touching_boundary  in  NEIGHBOR_COUNT  subtree boundary flag of neighbour i
- neighbor_increase  out  1  grow pulse to incident edges
- parent_vector  out  NEIGHBOR_COUNT  one-hot parent, or 0 if this PE is root
- cluster_parity  out  1  subtree parity
- cluster_touching_boundary  out  1  subtree touches boundary
- odd  out  1  cluster odd and unbounded
- root  out  ADDRESS_WIDTH  current root address
- busy  out  1  merge not yet converged

Behaviour:
Interface and reset:
- Interface is fixed: reset is synchronous and active-high; clock is clk.
- On reset: stage=last_stage=IDLE; FIFO empty; meas_count=0; meas_ready=0 during reset, 1 on the first cycle after; load_underflow=0; m=0; root=ADDRESS; parent_vector=0; cluster_parity=0; cluster_touching_boundary=0; odd=0; busy=0; quiet counter=0.
- Reset mid-operation flushes the FIFO and discards all cluster state.

Stage tracking:
- stage <= global_stage and last_stage <= stage every cycle, so stage lags global_stage by 1.
- load_entry = (stage==LOADING) && (last_stage!=LOADING).

FIFO:
- meas_ready = !full, computed from pre-cycle occupancy. A push is rejected when full even if a pop occurs in the same cycle.
- push = meas_valid && meas_ready.
- pop = load_entry && !empty: exactly one pop per loading entry, however long LOADING lasts.
- Simultaneous push and pop keeps meas_count unchanged. Pointers wrap modulo MEAS_DEPTH.

Load, on load_entry:
- b = head bit if non-empty. If empty, b=0 and load_underflow<=1 (sticky until reset).
- m<=b, cluster_parity<=b, odd<=b, cluster_touching_boundary<=0, root<=ADDRESS, parent_vector<=0, busy<=0, quiet<=0.

Grow:
- neighbor_increase = odd && stage==GROW && last_stage!=GROW, a 1-cycle pulse per GROW entry.

Merge, each cycle with stage==MERGE:
- Candidate set = channels with neighbor_fully_grown=1. minr = minimum neighbor_root over the set; sel = lowest-index channel holding minr.
- If the set is non-empty and minr<root: root<=minr, parent_vector<=onehot(sel).
- np = ^(neighbor_parent_vector & child_cluster_parity) ^ m.
- nb = |(neighbor_parent_vector & child_touching_boundary) | |neighbor_is_boundary.
- cluster_parity<=np; cluster_touching_boundary<=nb.
- odd: if parent_vector!=0, odd<=|(parent_vector & parent_odd). Otherwise odd<=np & ~nb. Uses the pre-update parent_vector.
- chg = root update, or np!=cluster_parity, or nb!=cluster_touching_boundary, or the computed next odd != odd.
- If chg: busy<=1, quiet<=0.
- Else: quiet<=quiet+1, saturating at QUIET_CYCLES. busy<=0 once quiet+1>=QUIET_CYCLES, otherwise busy holds.

Other stages:
- All cluster state and busy hold.

Optional Feature:
- Macro: PU_MERGE_CYCLE_COUNT_EN.
- Defined: adds output merge_cycles[15:0]. Cleared on reset and on load_entry. Increments, saturating at 16'hFFFF, on each MERGE cycle where busy==1 or chg==1.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Push 1,0,1 with MEAS_DEPTH=4, then three LOADING entries -> m/odd sequence 1,0,1; meas_count 3->0; load_underflow=0.
- Push 4 bits, hold meas_valid=1 with a 5th -> meas_ready=0, meas_count=4, 5th bit not stored. Then LOADING entry with valid still high -> count stays 4 that cycle, push accepted the next cycle.
- LOADING entry with FIFO empty -> odd=0, cluster_parity=0, load_underflow=1 and stays 1 through further loads.
- ADDRESS=5, channels 1 and 3 fully grown, both roots=2 -> after 1 MERGE cycle root=2, parent_vector=6'b000010, busy=1. After QUIET_CYCLES=2 further stable cycles busy=0.
- Root PE, m=1, channel 0 boundary=1, GROW entry -> no neighbor_increase. MERGE -> cluster_touching_boundary=1, odd=0.
- Reset asserted during MERGE with FIFO count 2 -> next cycle root=ADDRESS, busy=0, meas_count=0, meas_ready=1.
